// File: rtl/alu_pkg.sv
// Shared ALU definitions for alu_arbiter: opcodes, arbiter states, and the ALU function.
// Operands are carried at ALU_MAX_W bits; callers pass their real width so SLT and wrap use it.
package alu_pkg;

   localparam int ALU_MAX_W = 64;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_OR  = 3'd3,
      ALU_XOR = 3'd4,
      ALU_SLT = 3'd5
   } alu_op_e;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } arb_state_e;

   function automatic logic alu_op_legal(input logic [2:0] op);
      return (op <= 3'd5);
   endfunction

   // a and b must be zero-extended from width w; result is masked back to w bits.
   function automatic logic [ALU_MAX_W-1:0] alu_compute(input logic [ALU_MAX_W-1:0] a,
                                                        input logic [ALU_MAX_W-1:0] b,
                                                        input logic [2:0]           op,
                                                        input int                   w);
      logic [ALU_MAX_W-1:0] mask;
      logic [ALU_MAX_W-1:0] sgn;
      logic [ALU_MAX_W-1:0] r;
      logic                 sa;
      logic                 sb;
      logic                 lt;
      mask = (w >= ALU_MAX_W) ? '1 : ((ALU_MAX_W'(1) << w) - ALU_MAX_W'(1));
      sgn  = mask & ~(mask >> 1);
      sa   = |(a & sgn);
      sb   = |(b & sgn);
      lt   = (sa != sb) ? sa : (a < b);
      case (op)
         ALU_ADD: r = a + b;
         ALU_SUB: r = a - b;
         ALU_AND: r = a & b;
         ALU_OR:  r = a | b;
         ALU_XOR: r = a ^ b;
         ALU_SLT: r = lt ? mask : '0;
         default: r = '0;
      endcase
      return r & mask;
   endfunction

endpackage

// File: rtl/alu_arbiter_rr.sv
// Combinational round-robin arbiter: searches from ptr_i upward, wrapping at NREQ-1.
// The pointer register lives in the parent.
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IDW-1:0]  ptr_i,
   input  logic            en_i,
   output logic [NREQ-1:0] gnt_o,
   output logic [IDW-1:0]  gnt_idx_o,
   output logic            any_o
);

   logic            found;
   logic [IDW-1:0]  cand;

   always_comb begin
      found     = 1'b0;
      cand      = '0;
      gnt_idx_o = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = IDW'((int'(ptr_i) + k) % NREQ);
         if (!found && req_i[cand]) begin
            found     = 1'b1;
            gnt_idx_o = cand;
         end
      end
      any_o = found && en_i;
      gnt_o = '0;
      if (any_o) gnt_o[gnt_idx_o] = 1'b1;
   end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin shared ALU with one registered, ID-tagged response channel.
// Optional resp_zero output enabled by defining ALU_ARB_ZERO_FLAG_EN.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int N    = 32,
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req_valid,
   output logic [NREQ-1:0]         req_ready,
   input  logic [NREQ-1:0][N-1:0]  req_a,
   input  logic [NREQ-1:0][N-1:0]  req_b,
   input  logic [NREQ-1:0][2:0]    req_op,
   output logic                    resp_valid,
   input  logic                    resp_ready,
   output logic [IDW-1:0]          resp_id,
   output logic [N-1:0]            resp_result,
   output logic                    resp_err
`ifdef ALU_ARB_ZERO_FLAG_EN
   ,output logic                   resp_zero
`endif
);

   arb_state_e           state_q, state_d;
   logic [IDW-1:0]       ptr_q, ptr_d;
   logic [IDW-1:0]       id_q, id_d;
   logic [N-1:0]         result_q, result_d;
   logic                 err_q, err_d;
   logic                 arb_en;
   logic                 accept;
   logic [IDW-1:0]       gnt_idx;
   logic [ALU_MAX_W-1:0] a_ext, b_ext, res_full;

   assign arb_en = (state_q == IDLE) || resp_ready;

   rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
      .req_i     (req_valid),
      .ptr_i     (ptr_q),
      .en_i      (arb_en),
      .gnt_o     (req_ready),
      .gnt_idx_o (gnt_idx),
      .any_o     (accept)
   );

   always_comb begin
      a_ext          = '0;
      b_ext          = '0;
      a_ext[N-1:0]   = req_a[gnt_idx];
      b_ext[N-1:0]   = req_b[gnt_idx];
      res_full       = alu_compute(a_ext, b_ext, req_op[gnt_idx], N);
   end

   // ptr_q holds the first index to search, i.e. one past the last grant.
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      id_d     = id_q;
      result_d = result_q;
      err_d    = err_q;
      if (accept) begin
         state_d  = HOLD;
         id_d     = gnt_idx;
         result_d = res_full[N-1:0];
         err_d    = !alu_op_legal(req_op[gnt_idx]);
         ptr_d    = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
      end else if (state_q == HOLD && resp_ready) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         ptr_q    <= '0;
         id_q     <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         id_q     <= id_d;
         result_q <= result_d;
         err_q    <= err_d;
      end
   end

   assign resp_valid  = (state_q == HOLD);
   assign resp_id     = id_q;
   assign resp_result = result_q;
   assign resp_err    = err_q;

`ifdef ALU_ARB_ZERO_FLAG_EN
   logic zero_q;

   always_ff @(posedge clk) begin
      if (rst)         zero_q <= 1'b0;
      else if (accept) zero_q <= (result_d == '0);
   end

   assign resp_zero = zero_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized traffic
// against a transaction-level reference model.
module tb_alu_arbiter;

   localparam int N    = 32;
   localparam int NREQ = 4;
   localparam int IDW  = $clog2(NREQ);

   logic                   clk = 1'b0;
   logic                   rst;
   logic [NREQ-1:0]        req_valid;
   logic [NREQ-1:0]        req_ready;
   logic [NREQ-1:0][N-1:0] req_a;
   logic [NREQ-1:0][N-1:0] req_b;
   logic [NREQ-1:0][2:0]   req_op;
   logic                   resp_valid;
   logic                   resp_ready;
   logic [IDW-1:0]         resp_id;
   logic [N-1:0]           resp_result;
   logic                   resp_err;
`ifdef ALU_ARB_ZERO_FLAG_EN
   logic                   resp_zero;
`endif

   int checks = 0;
   int errors = 0;

   // reference model state
   logic        m_hold;
   int          m_last;
   logic [31:0] m_res;
   int          m_id;
   logic        m_err;

   always #5 clk = ~clk;

   alu_arbiter #(.N(N), .NREQ(NREQ)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_a       (req_a),
      .req_b       (req_b),
      .req_op      (req_op),
      .resp_valid  (resp_valid),
      .resp_ready  (resp_ready),
      .resp_id     (resp_id),
      .resp_result (resp_result),
      .resp_err    (resp_err)
`ifdef ALU_ARB_ZERO_FLAG_EN
      ,.resp_zero  (resp_zero)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] op, output logic err);
      err = 1'b0;
      case (op)
         3'd0: return a + b;
         3'd1: return a - b;
         3'd2: return a & b;
         3'd3: return a | b;
         3'd4: return a ^ b;
         3'd5: return ($signed(a) < $signed(b)) ? 32'hFFFF_FFFF : 32'h0;
         default: begin
            err = 1'b1;
            return 32'h0;
         end
      endcase
   endfunction

   // One clock: check req_ready with current inputs, advance the model at the edge,
   // then check the registered response.
   task automatic tick();
      int              g;
      int              idx;
      logic [NREQ-1:0] exp_rdy;
      logic            e;
      #1;
      g = -1;
      if (req_valid != '0 && (!m_hold || resp_ready)) begin
         for (int k = 0; k < NREQ; k++) begin
            idx = (m_last + 1 + k) % NREQ;
            if (g < 0 && req_valid[idx]) g = idx;
         end
      end
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("req_ready", req_ready, exp_rdy);
      @(posedge clk);
      if (rst) begin
         m_hold = 1'b0; m_last = -1; m_res = '0; m_id = 0; m_err = 1'b0;
      end else if (g >= 0) begin
         m_res  = ref_alu(req_a[g], req_b[g], req_op[g], e);
         m_err  = e;
         m_id   = g;
         m_last = g;
         m_hold = 1'b1;
      end else if (m_hold && resp_ready) begin
         m_hold = 1'b0;
      end
      @(negedge clk);
      chk("resp_valid", resp_valid, m_hold);
      chk("resp_id", resp_id, m_id);
      chk("resp_result", resp_result, m_res);
      chk("resp_err", resp_err, m_err);
`ifdef ALU_ARB_ZERO_FLAG_EN
      chk("resp_zero", resp_zero, (m_res == 32'h0));
`endif
   endtask

   task automatic load0(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
      req_valid = 4'b0001;
      req_a[0]  = a;
      req_b[0]  = b;
      req_op[0] = op;
   endtask

   function automatic logic [31:0] rnd_operand();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int seq[5] = '{0, 1, 2, 3, 0};
      logic [NREQ-1:0] onehot;

      m_hold = 1'b0; m_last = -1; m_res = '0; m_id = 0; m_err = 1'b0;
      rst = 1'b1; req_valid = '0; resp_ready = 1'b0;
      req_a = '0; req_b = '0; req_op = '0;
      @(negedge clk);
      tick();
      tick();
      chk("reset_valid", resp_valid, 1'b0);
      chk("reset_result", resp_result, 32'h0);
      rst = 1'b0;

      // single request
      load0(32'd5, 32'd7, 3'd0);
      tick();
      chk("t1_id", resp_id, 0);
      chk("t1_result", resp_result, 32'd12);
      req_valid = '0;
      tick();

      // round robin from reset
      rst = 1'b1; tick(); rst = 1'b0;
      req_valid = 4'b1111; resp_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         req_a[i] = 32'(i * 10); req_b[i] = 32'd1; req_op[i] = 3'd0;
      end
      for (int i = 0; i < 5; i++) begin
         onehot = '0;
         onehot[seq[i]] = 1'b1;
         #1;
         chk("rr_grant", req_ready, onehot);
         tick();
         chk("rr_id", resp_id, seq[i]);
         chk("rr_result", resp_result, 32'(seq[i] * 10 + 1));
      end

      // backpressure: last grant 1, then 0110 held while consumer stalls
      rst = 1'b1; tick(); rst = 1'b0;
      resp_ready = 1'b0;
      req_valid  = 4'b0010;
      tick();
      req_valid = 4'b0110;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("bp_ready", req_ready, 4'b0000);
         chk("bp_id", resp_id, 1);
      end
      resp_ready = 1'b1;
      #1;
      chk("bp_next_grant", req_ready, 4'b0100);
      tick();

      // arithmetic edges
      rst = 1'b1; req_valid = '0; tick(); rst = 1'b0;
      load0(32'h0, 32'h1, 3'd1);          tick(); chk("sub_wrap", resp_result, 32'hFFFF_FFFF);
      load0(32'h8000_0000, 32'h1, 3'd5);  tick(); chk("slt_neg", resp_result, 32'hFFFF_FFFF);
      load0(32'h1, 32'h8000_0000, 3'd5);  tick(); chk("slt_pos", resp_result, 32'h0);
      load0(32'h1234, 32'h5678, 3'd7);    tick();
      chk("bad_op_res", resp_result, 32'h0);
      chk("bad_op_err", resp_err, 1'b1);
`ifdef ALU_ARB_ZERO_FLAG_EN
      load0(32'hA5A5_A5A5, 32'hA5A5_A5A5, 3'd4); tick(); chk("zero_xor", resp_zero, 1'b1);
      load0(32'd1, 32'd1, 3'd0);                 tick(); chk("zero_add", resp_zero, 1'b0);
`endif

      // reset while holding
      resp_ready = 1'b0;
      load0(32'd3, 32'd4, 3'd0);
      tick();
      rst = 1'b1; req_valid = '0;
      tick();
      chk("rst_hold_valid", resp_valid, 1'b0);
      chk("rst_hold_id", resp_id, 0);
      rst = 1'b0;
      req_valid = 4'b1001;
      #1;
      chk("rst_grant0", req_ready, 4'b0001);
      tick();

      // randomized traffic
      for (int c = 0; c < 400; c++) begin
         rst        = ($urandom_range(0, 60) == 0);
         req_valid  = NREQ'($urandom);
         resp_ready = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < NREQ; i++) begin
            req_a[i]  = rnd_operand();
            req_b[i]  = rnd_operand();
            req_op[i] = 3'($urandom_range(0, 7));
         end
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
